axi4_lite_slave_regs: RTL and testbench
=======================================

# axi4_lite_slave_regs

AXI4-Lite slave register file that terminates the transactions issued by our AXI4-Lite master, directly downstream of it on the same five channels. It accepts write address and write data independently in either order, applies byte strobes to an internal register array, and returns BRESP and RDATA/RRESP. Register contents are exported flat for the surrounding logic, together with a one-cycle write-event strobe.

## Interface
- DATA_WIDTH, 32, bus data width; only 32 is supported.
- ADDRESS_WIDTH, 32, bus address width.
- NUM_REGS, 16, number of DATA_WIDTH registers; must be a power of 2, minimum 2.
- ACLK  in  1  clock; all logic is on the rising edge.
- ARESETn  in  1  reset, asynchronous, active-low; there is no internal synchronizer.
- AWADDR/AWPROT/AWVALID  in  ADDRESS_WIDTH/3/1  write address channel; AWPROT is accepted and ignored.
- AWREADY  out  1  write address ready.
- WDATA/WSTRB/WVALID  in  DATA_WIDTH/DATA_WIDTH/8/1  write data channel.
- WREADY  out  1  write data ready.
- BRESP/BVALID  out  2/1  write response; BREADY  in  1.
- ARADDR/ARPROT/ARVALID  in  ADDRESS_WIDTH/3/1  read address channel; ARPROT is ignored.
- ARREADY  out  1  read address ready.
- RDATA/RRESP/RVALID  out  DATA_WIDTH/2/1  read data channel; RREADY  in  1.
- regs_flat  out  NUM_REGS*DATA_WIDTH  register contents; register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- reg_wr_pulse  out  1  single-cycle pulse on each committed write.
- reg_wr_idx  out  log2(NUM_REGS)  index of the committed write, valid while reg_wr_pulse is high.

## Operation
- Addressing: byte addresses. idx = addr[2 +: log2(NUM_REGS)]. addr[1:0] is ignored.
- Write path:
  - There are two single-entry holding registers, AW_HELD and W_HELD.
  - AWREADY = !AW_HELD && !BVALID. WREADY = !W_HELD && !BVALID. Both are registered.
  - A handshake on a channel sets its HELD flag and latches that channel's payload.
  - When AW_HELD && W_HELD, the write commits on the next edge:
    - For each byte lane b with WSTRB[b]=1, reg[idx] byte b takes WDATA byte b. Other lanes keep their value.
    - BVALID goes to 1 and BRESP takes its value.
    - reg_wr_pulse goes to 1 for one cycle.
    - Both HELD flags clear.
  - BVALID holds, with BRESP stable, until BVALID&&BREADY. BVALID clears on that edge and the readies rise on the following cycle.
- Read path, with states R_IDLE and R_RESP:
  - R_IDLE: ARREADY=1. On ARVALID&&ARREADY, latch RDATA=reg[idx], set RRESP, set RVALID=1, ARREADY=0, and go to R_RESP.
  - R_RESP: hold RDATA/RRESP/RVALID until RVALID&&RREADY. Then RVALID=0 and return to R_IDLE. ARREADY=1 on the next cycle.
- Read and write paths are fully independent and may be active concurrently.
- BRESP/RRESP are OKAY (2'b00) unless the address check described under Configuration fires.

## Timing
- Reset values:
  - AWREADY, WREADY, ARREADY, BVALID, RVALID, reg_wr_pulse: 0.
  - BRESP, RRESP: 2'b00. RDATA: 0. reg_wr_idx: 0. All registers: 0.
  - After ARESETn deasserts, the readies are 1 from the first ACLK edge onward.
- Write latency: the later of the AW/W handshakes occurs at edge N. The commit, BVALID=1 and reg_wr_pulse=1 happen at edge N+1.
- AW before W, W before AW, and both in the same cycle are all legal and give identical results.
- A second AW while AW_HELD is blocked by AWREADY=0. The same applies to W.
- Read latency: AR handshake at edge N, RVALID=1 at edge N+1.
- Read/write same-index collision: if an AR handshake coincides with a write commit, RDATA returns the pre-write value.
- Back-pressure: BREADY or RREADY held low stalls the corresponding path indefinitely, with no loss of data.
- Reset mid-transaction: held AW/W and a pending B or R are discarded, and all outputs return to their reset values immediately.

## Configuration
- AXI4_LITE_SLAVE_ADDR_CHECK_EN
  - Defined: an address with any bit set above bit 2+log2(NUM_REGS)-1 is out of range.
    - Out-of-range writes are dropped, with no register change and no reg_wr_pulse, and respond BRESP=SLVERR (2'b10).
    - Out-of-range reads respond RDATA=0, RRESP=SLVERR.
  - Undefined: upper address bits are ignored, so the index aliases, and every response is OKAY.

## Structure
- Shared package axi4_lite_pkg holds:
  - Response constants RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
  - The default PROT value 3'b001, shared with the master.
- One sub-module, axi4_lite_regfile: the byte-strobed register array with a write port and an asynchronous read port, plus the flat export.
- Handshake and FSM logic live in the top module.

## Test plan
- Reset, then AW addr 0x04 and W 0xDEADBEEF/WSTRB 0xF in the same cycle, BREADY=1 -> BVALID one cycle later with BRESP=00, reg1=0xDEADBEEF, reg_wr_pulse with idx=1.
- W 0x000000AA/WSTRB 0x1 three cycles before AW 0x04 -> reg1=0xDEADBEAA, WREADY low until the B handshake.
- AR 0x04 with RREADY held low for 5 cycles -> RVALID stays 1, RDATA=0xDEADBEAA is stable, ARREADY stays 0, and the next AR is accepted the cycle after RREADY=1.
- AR 0x08 coinciding with a write commit to 0x08 of 0x12345678 (old value 0) -> RDATA=0, and a subsequent read returns 0x12345678.
- With ADDR_CHECK_EN and NUM_REGS=16: write to 0x40 -> BRESP=10 with no register change; read of 0x40 -> RDATA=0, RRESP=10. Without the macro: write to 0x40 updates reg0 with OKAY.
- ARESETn pulsed low while AW_HELD and RVALID are set -> all outputs 0, registers 0, and the next full write completes normally.

Source files
------------

// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions used by master and slave.
// Response codes, default PROT value, slave read FSM states.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] PROT_DEFAULT = 3'b001;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } r_state_e;

endpackage

// File: rtl/axi4_lite_regfile.sv
// Byte-strobed register array: one write port, async read port.
// Ports: ACLK/ARESETn, we/widx/wdata/wstrb, ridx->rdata, regs_flat.
module axi4_lite_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  parameter int IDXW       = $clog2(NUM_REGS)
) (
  input  logic                           ACLK,
  input  logic                           ARESETn,
  input  logic                           we,
  input  logic [IDXW-1:0]                widx,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
  input  logic [IDXW-1:0]                ridx,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat
);

  logic [DATA_WIDTH-1:0] mem [NUM_REGS];

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int i = 0; i < NUM_REGS; i++)
        mem[i] <= '0;
    end else if (we) begin
      for (int b = 0; b < DATA_WIDTH/8; b++)
        if (wstrb[b])
          mem[widx][b*8 +: 8] <= wdata[b*8 +: 8];
    end
  end

  // Read sees pre-edge contents, so a colliding read gets old data.
  assign rdata = mem[ridx];

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[g*DATA_WIDTH +: DATA_WIDTH] = mem[g];
  end

endmodule

// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite slave register file; AW/W in any order, byte strobes.
// Ports: AXI4-Lite slave channels, regs_flat, reg_wr_pulse/idx.
// Option: AXI4_LITE_SLAVE_ADDR_CHECK_EN -> SLVERR on out-of-range.
module axi4_lite_slave_regs
  import axi4_lite_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int NUM_REGS      = 16
) (
  input  logic                           ACLK,
  input  logic                           ARESETn,
  input  logic [ADDRESS_WIDTH-1:0]       AWADDR,
  input  logic [2:0]                     AWPROT,
  input  logic                           AWVALID,
  output logic                           AWREADY,
  input  logic [DATA_WIDTH-1:0]          WDATA,
  input  logic [DATA_WIDTH/8-1:0]        WSTRB,
  input  logic                           WVALID,
  output logic                           WREADY,
  output logic [1:0]                     BRESP,
  output logic                           BVALID,
  input  logic                           BREADY,
  input  logic [ADDRESS_WIDTH-1:0]       ARADDR,
  input  logic [2:0]                     ARPROT,
  input  logic                           ARVALID,
  output logic                           ARREADY,
  output logic [DATA_WIDTH-1:0]          RDATA,
  output logic [1:0]                     RRESP,
  output logic                           RVALID,
  input  logic                           RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat,
  output logic                           reg_wr_pulse,
  output logic [$clog2(NUM_REGS)-1:0]    reg_wr_idx
);

  localparam int IDXW  = $clog2(NUM_REGS);
  localparam int STRBW = DATA_WIDTH / 8;

  logic                     aw_held, w_held;
  logic [ADDRESS_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0]    w_data_q;
  logic [STRBW-1:0]         w_strb_q;

  logic aw_hs, w_hs, commit;
  logic aw_held_n, w_held_n, bvalid_n;
  logic wr_ok, rd_ok;
  logic [IDXW-1:0]       wr_idx, rd_idx;
  logic [DATA_WIDTH-1:0] rd_data;
  r_state_e r_state;

  assign aw_hs  = AWVALID && AWREADY;
  assign w_hs   = WVALID && WREADY;
  assign commit = aw_held && w_held;
  assign wr_idx = aw_addr_q[2 +: IDXW];
  assign rd_idx = ARADDR[2 +: IDXW];

  assign aw_held_n = !commit && (aw_held || aw_hs);
  assign w_held_n  = !commit && (w_held || w_hs);
  assign bvalid_n  = commit || (BVALID && !BREADY);

`ifdef AXI4_LITE_SLAVE_ADDR_CHECK_EN
  assign wr_ok = (aw_addr_q >> (2 + IDXW)) == '0;
  assign rd_ok = (ARADDR >> (2 + IDXW)) == '0;
`else
  assign wr_ok = 1'b1;
  assign rd_ok = 1'b1;
`endif

  logic unused_ok;
  assign unused_ok = ^{AWPROT, ARPROT, aw_addr_q, ARADDR};

  // Readies come from next-state so they drop on the handshake edge.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      aw_addr_q    <= '0;
      w_data_q     <= '0;
      w_strb_q     <= '0;
      AWREADY      <= 1'b0;
      WREADY       <= 1'b0;
      BVALID       <= 1'b0;
      BRESP        <= RESP_OKAY;
      reg_wr_pulse <= 1'b0;
      reg_wr_idx   <= '0;
    end else begin
      aw_held      <= aw_held_n;
      w_held       <= w_held_n;
      BVALID       <= bvalid_n;
      AWREADY      <= !aw_held_n && !bvalid_n;
      WREADY       <= !w_held_n && !bvalid_n;
      reg_wr_pulse <= commit && wr_ok;
      if (aw_hs)
        aw_addr_q <= AWADDR;
      if (w_hs) begin
        w_data_q <= WDATA;
        w_strb_q <= WSTRB;
      end
      if (commit) begin
        BRESP <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        if (wr_ok)
          reg_wr_idx <= wr_idx;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state <= R_IDLE;
      ARREADY <= 1'b0;
      RVALID  <= 1'b0;
      RDATA   <= '0;
      RRESP   <= RESP_OKAY;
    end else begin
      unique case (r_state)
        R_IDLE: begin
          if (ARVALID && ARREADY) begin
            RDATA   <= rd_ok ? rd_data : '0;
            RRESP   <= rd_ok ? RESP_OKAY : RESP_SLVERR;
            RVALID  <= 1'b1;
            ARREADY <= 1'b0;
            r_state <= R_RESP;
          end else begin
            ARREADY <= 1'b1;
          end
        end
        R_RESP: begin
          if (RREADY) begin
            RVALID  <= 1'b0;
            ARREADY <= 1'b1;
            r_state <= R_IDLE;
          end
        end
      endcase
    end
  end

  axi4_lite_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .IDXW       (IDXW)
  ) u_regfile (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .we        (commit && wr_ok),
    .widx      (wr_idx),
    .wdata     (w_data_q),
    .wstrb     (w_strb_q),
    .ridx      (rd_idx),
    .rdata     (rd_data),
    .regs_flat (regs_flat)
  );

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Directed testbench for axi4_lite_slave_regs.
// Honours AXI4_LITE_SLAVE_ADDR_CHECK_EN for the range test.
module tb_axi4_lite_slave_regs;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic [31:0] AWADDR;
  logic [2:0]  AWPROT;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [31:0] ARADDR;
  logic [2:0]  ARPROT;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;
  logic [511:0] regs_flat;
  logic        reg_wr_pulse;
  logic [3:0]  reg_wr_idx;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 ACLK = ~ACLK;

  axi4_lite_slave_regs dut (
    .ACLK         (ACLK),
    .ARESETn      (ARESETn),
    .AWADDR       (AWADDR),
    .AWPROT       (AWPROT),
    .AWVALID      (AWVALID),
    .AWREADY      (AWREADY),
    .WDATA        (WDATA),
    .WSTRB        (WSTRB),
    .WVALID       (WVALID),
    .WREADY       (WREADY),
    .BRESP        (BRESP),
    .BVALID       (BVALID),
    .BREADY       (BREADY),
    .ARADDR       (ARADDR),
    .ARPROT       (ARPROT),
    .ARVALID      (ARVALID),
    .ARREADY      (ARREADY),
    .RDATA        (RDATA),
    .RRESP        (RRESP),
    .RVALID       (RVALID),
    .RREADY       (RREADY),
    .regs_flat    (regs_flat),
    .reg_wr_pulse (reg_wr_pulse),
    .reg_wr_idx   (reg_wr_idx)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rg(input int i);
    return regs_flat[i*32 +: 32];
  endfunction

  task automatic tick;
    @(posedge ACLK);
    #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [1:0] resp,
                          output logic pulse, output logic [3:0] idx);
    logic ah, wh;
    int n;
    AWADDR = a; WDATA = d; WSTRB = s;
    AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
    n = 0;
    while ((AWVALID || WVALID) && n < 20) begin
      ah = AWVALID && AWREADY;
      wh = WVALID && WREADY;
      tick; n++;
      if (ah) AWVALID = 1'b0;
      if (wh) WVALID = 1'b0;
    end
    while (!BVALID && n < 20) begin
      tick; n++;
    end
    if (!BVALID) chk("wr_timeout", 1'b0, 1'b1);
    resp = BRESP; pulse = reg_wr_pulse; idx = reg_wr_idx;
    AWVALID = 1'b0; WVALID = 1'b0;
    tick;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d,
                         output logic [1:0] resp);
    logic hs;
    int n;
    ARADDR = a; ARVALID = 1'b1; RREADY = 1'b1;
    n = 0;
    while (ARVALID && n < 20) begin
      hs = ARREADY;
      tick; n++;
      if (hs) ARVALID = 1'b0;
    end
    while (!RVALID && n < 20) begin
      tick; n++;
    end
    if (!RVALID) chk("rd_timeout", 1'b0, 1'b1);
    d = RDATA; resp = RRESP;
    ARVALID = 1'b0;
    tick;
    RREADY = 1'b0;
  endtask

  logic [1:0]  resp;
  logic        pulse;
  logic [3:0]  idx;
  logic [31:0] rd;
  logic [511:0] exp_flat;

  initial begin
    ARESETn = 1'b0;
    AWADDR = '0; AWPROT = 3'b001; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b0;
    ARADDR = '0; ARPROT = 3'b001; ARVALID = 1'b0; RREADY = 1'b0;
    #2;
    chk("rst_awready", AWREADY, 1'b0);
    chk("rst_arready", ARREADY, 1'b0);
    chk("rst_bvalid", BVALID, 1'b0);
    chk("rst_rvalid", RVALID, 1'b0);
    chk("rst_flat", regs_flat == '0, 1'b1);
    @(negedge ACLK);
    ARESETn = 1'b1;
    #1;
    chk("pre_edge_wready", WREADY, 1'b0);
    tick;
    chk("post_rst_awready", AWREADY, 1'b1);
    chk("post_rst_wready", WREADY, 1'b1);
    chk("post_rst_arready", ARREADY, 1'b1);

    // AW and W in the same cycle
    AWADDR = 32'h4; AWVALID = 1'b1;
    WDATA = 32'hDEADBEEF; WSTRB = 4'hF; WVALID = 1'b1;
    BREADY = 1'b1;
    tick;
    AWVALID = 1'b0; WVALID = 1'b0;
    chk("t1_awready_lo", AWREADY, 1'b0);
    chk("t1_bvalid_lat", BVALID, 1'b0);
    tick;
    chk("t1_bvalid", BVALID, 1'b1);
    chk("t1_bresp", BRESP, 2'b00);
    chk("t1_pulse", reg_wr_pulse, 1'b1);
    chk("t1_idx", reg_wr_idx, 4'd1);
    chk("t1_reg1", rg(1), 32'hDEADBEEF);
    tick;
    chk("t1_bdone", BVALID, 1'b0);
    chk("t1_pulse_off", reg_wr_pulse, 1'b0);
    chk("t1_awready_back", AWREADY, 1'b1);

    // W three cycles ahead of AW, single strobe
    BREADY = 1'b0;
    WDATA = 32'h000000AA; WSTRB = 4'h1; WVALID = 1'b1;
    tick;
    WVALID = 1'b0;
    chk("t2_wready_lo", WREADY, 1'b0);
    chk("t2_awready_hi", AWREADY, 1'b1);
    tick;
    tick;
    chk("t2_no_commit", BVALID, 1'b0);
    AWADDR = 32'h4; AWVALID = 1'b1;
    tick;
    AWVALID = 1'b0;
    tick;
    chk("t2_bvalid", BVALID, 1'b1);
    chk("t2_reg1", rg(1), 32'hDEADBEAA);
    chk("t2_wready_b", WREADY, 1'b0);
    tick;
    chk("t2_bhold", BVALID, 1'b1);
    chk("t2_wready_b2", WREADY, 1'b0);
    BREADY = 1'b1;
    tick;
    chk("t2_bdone", BVALID, 1'b0);
    chk("t2_wready_back", WREADY, 1'b1);
    BREADY = 1'b0;

    // Read with RREADY stalled; second AR must wait
    ARADDR = 32'h4; ARVALID = 1'b1; RREADY = 1'b0;
    tick;
    ARADDR = 32'h0;
    for (int i = 0; i < 5; i++) begin
      chk("t3_rvalid", RVALID, 1'b1);
      chk("t3_rdata", RDATA, 32'hDEADBEAA);
      chk("t3_arready", ARREADY, 1'b0);
      if (i < 4) tick;
    end
    RREADY = 1'b1;
    tick;
    RREADY = 1'b0;
    chk("t3_rdone", RVALID, 1'b0);
    chk("t3_arready_back", ARREADY, 1'b1);
    tick;
    ARVALID = 1'b0;
    chk("t3_ar2_rvalid", RVALID, 1'b1);
    chk("t3_ar2_rdata", RDATA, 32'h0);
    RREADY = 1'b1;
    tick;
    RREADY = 1'b0;

    // Read coinciding with commit to the same index
    AWADDR = 32'h8; AWVALID = 1'b1;
    WDATA = 32'h12345678; WSTRB = 4'hF; WVALID = 1'b1;
    tick;
    AWVALID = 1'b0; WVALID = 1'b0;
    ARADDR = 32'h8; ARVALID = 1'b1;
    tick;
    ARVALID = 1'b0;
    chk("t4_rvalid", RVALID, 1'b1);
    chk("t4_rdata_old", RDATA, 32'h0);
    chk("t4_bvalid", BVALID, 1'b1);
    chk("t4_reg2", rg(2), 32'h12345678);
    chk("t4_idx", reg_wr_idx, 4'd2);
    RREADY = 1'b1; BREADY = 1'b1;
    tick;
    RREADY = 1'b0; BREADY = 1'b0;
    do_read(32'h8, rd, resp);
    chk("t4_rdata_new", rd, 32'h12345678);
    chk("t4_rresp", resp, 2'b00);

    // Out-of-range address
    do_write(32'h40, 32'h55AA55AA, 4'hF, resp, pulse, idx);
`ifdef AXI4_LITE_SLAVE_ADDR_CHECK_EN
    chk("t5_bresp", resp, 2'b10);
    chk("t5_pulse", pulse, 1'b0);
    chk("t5_reg0", rg(0), 32'h0);
    do_read(32'h40, rd, resp);
    chk("t5_rdata", rd, 32'h0);
    chk("t5_rresp", resp, 2'b10);
`else
    chk("t5_bresp", resp, 2'b00);
    chk("t5_pulse", pulse, 1'b1);
    chk("t5_idx", idx, 4'd0);
    chk("t5_reg0", rg(0), 32'h55AA55AA);
    do_read(32'h40, rd, resp);
    chk("t5_rdata", rd, 32'h55AA55AA);
    chk("t5_rresp", resp, 2'b00);
`endif
    BREADY = 1'b0;

    // Reset with AW held and R pending
    AWADDR = 32'hC; AWVALID = 1'b1;
    tick;
    AWVALID = 1'b0;
    ARADDR = 32'h4; ARVALID = 1'b1; RREADY = 1'b0;
    tick;
    ARVALID = 1'b0;
    chk("t6_rvalid_pre", RVALID, 1'b1);
    #2;
    ARESETn = 1'b0;
    #1;
    chk("t6_rvalid", RVALID, 1'b0);
    chk("t6_rdata", RDATA, 32'h0);
    chk("t6_arready", ARREADY, 1'b0);
    chk("t6_awready", AWREADY, 1'b0);
    chk("t6_flat", regs_flat == '0, 1'b1);
    @(negedge ACLK);
    ARESETn = 1'b1;
    tick;
    chk("t6_awready_back", AWREADY, 1'b1);
    WDATA = 32'h11111111; WSTRB = 4'hF; WVALID = 1'b1;
    tick;
    WVALID = 1'b0;
    tick;
    tick;
    chk("t6_stale_aw", BVALID, 1'b0);
    AWADDR = 32'hC; AWVALID = 1'b1;
    tick;
    AWVALID = 1'b0;
    tick;
    chk("t6_bvalid", BVALID, 1'b1);
    chk("t6_bresp", BRESP, 2'b00);
    chk("t6_pulse", reg_wr_pulse, 1'b1);
    chk("t6_idx", reg_wr_idx, 4'd3);
    exp_flat = '0;
    exp_flat[3*32 +: 32] = 32'h11111111;
    chk("t6_flat_after", regs_flat == exp_flat, 1'b1);
    BREADY = 1'b1;
    tick;
    chk("t6_bdone", BVALID, 1'b0);
    BREADY = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
